ram_arbiter: RTL and testbench

Sequential arbiter sharing the single RAM port between the instruction and data requesters of `CPUS` cores. It sits between the per-core cache request ports and the RAM model, above the coherence logic. It grants one transaction at a time through a registered IDLE/BUSY/DONE state machine. Data requests have priority over instruction requests; round-robin selects among cores.

---
 rtl/ram_arbiter.sv | 256 +++++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - sequential IDLE/BUSY/DONE arbiter sharing one RAM port among CPUS cores
// Optional build macro: RAM_ARB_TIMEOUT_EN (abort a BUSY transaction after TIMEOUT cycles)

module ram_arbiter #(
  parameter int CPUS    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0]  RAM_ACCESS = 2'd2;
  localparam logic [2:0]  NCORES     = 3'(CPUS);

  state_e                 state_q, state_d;
  logic [1:0]             rr_ptr_q, rr_ptr_d;
  logic [1:0]             gnt_core_q, gnt_core_d;
  logic                   gnt_data_q, gnt_data_d;
  logic                   gnt_wr_q, gnt_wr_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            store_q, store_d;
  logic [CPUS-1:0][31:0]  iload_q, iload_d;
  logic [CPUS-1:0][31:0]  dload_q, dload_d;

`ifdef RAM_ARB_TIMEOUT_EN
  logic [15:0]            cnt_q, cnt_d;
  logic                   tmo_q, tmo_d;
`else
  logic                   unused_timeout;
  assign unused_timeout = |16'(TIMEOUT);
`endif

  // Requests padded to 4 bits so a 2-bit core index selects them without width games
  logic [3:0] d_act4, i_act4;
  assign d_act4 = 4'(dREN | dWEN);
  assign i_act4 = 4'(iREN);

  logic       d_found, i_found;
  logic [1:0] d_sel, i_sel;
  logic [2:0] scan_sum;

  // Round-robin scan from rr_ptr; reverse order so the smallest offset is written last and wins
  always_comb begin
    d_found  = 1'b0;
    i_found  = 1'b0;
    d_sel    = rr_ptr_q;
    i_sel    = rr_ptr_q;
    scan_sum = 3'd0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr_q} + 3'(k);
      if (scan_sum >= NCORES) begin
        scan_sum = scan_sum - NCORES;
      end
      if (d_act4[scan_sum[1:0]]) begin
        d_found = 1'b1;
        d_sel   = scan_sum[1:0];
      end
      if (i_act4[scan_sum[1:0]]) begin
        i_found = 1'b1;
        i_sel   = scan_sum[1:0];
      end
    end
  end

  logic [1:0]  win_core;
  logic [31:0] win_daddr, win_iaddr, win_dstore;
  logic        win_wen;

  // Mux the winning core's request fields; the data class beats the instruction class
  always_comb begin
    win_core   = d_found ? d_sel : i_sel;
    win_daddr  = 32'd0;
    win_iaddr  = 32'd0;
    win_dstore = 32'd0;
    win_wen    = 1'b0;
    for (int c = 0; c < CPUS; c++) begin
      if (2'(c) == win_core) begin
        win_daddr  = daddr[c];
        win_iaddr  = iaddr[c];
        win_dstore = dstore[c];
        win_wen    = dWEN[c];
      end
    end
  end

  logic [2:0] rr_next;

  // Pointer moves to the core after the one just served, wrapping at CPUS
  always_comb begin
    rr_next = {1'b0, gnt_core_q} + 3'd1;
    if (rr_next >= NCORES) begin
      rr_next = rr_next - NCORES;
    end
  end

  // Next-state logic: latch a grant in IDLE, wait for ACCESS in BUSY, release in DONE
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_core_d = gnt_core_q;
    gnt_data_d = gnt_data_q;
    gnt_wr_d   = gnt_wr_q;
    addr_d     = addr_q;
    store_d    = store_q;
    iload_d    = iload_q;
    dload_d    = dload_q;
`ifdef RAM_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (d_found || i_found) begin
          state_d    = ST_BUSY;
          gnt_core_d = win_core;
          gnt_data_d = d_found;
          gnt_wr_d   = d_found && win_wen;
          addr_d     = d_found ? win_daddr : win_iaddr;
          store_d    = (d_found && win_wen) ? win_dstore : 32'd0;
`ifdef RAM_ARB_TIMEOUT_EN
          cnt_d      = 16'd0;
          tmo_d      = 1'b0;
`endif
        end
      end
      ST_BUSY: begin
        if (ramstate == RAM_ACCESS) begin
          state_d = ST_DONE;
          for (int c = 0; c < CPUS; c++) begin
            if (2'(c) == gnt_core_q) begin
              if (!gnt_data_q) begin
                iload_d[c] = ramload;
              end else if (!gnt_wr_q) begin
                dload_d[c] = ramload;
              end
            end
          end
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (cnt_q + 16'd1 == 16'(TIMEOUT)) begin
          state_d = ST_DONE;
          tmo_d   = 1'b1;
          for (int c = 0; c < CPUS; c++) begin
            if (2'(c) == gnt_core_q) begin
              if (!gnt_data_q) begin
                iload_d[c] = 32'hBAD1BAD1;
              end else if (!gnt_wr_q) begin
                dload_d[c] = 32'hBAD1BAD1;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        rr_ptr_d = rr_next[1:0];
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 2'd0;
      gnt_core_q <= 2'd0;
      gnt_data_q <= 1'b0;
      gnt_wr_q   <= 1'b0;
      addr_q     <= 32'd0;
      store_q    <= 32'd0;
      iload_q    <= '0;
      dload_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_core_q <= gnt_core_d;
      gnt_data_q <= gnt_data_d;
      gnt_wr_q   <= gnt_wr_d;
      addr_q     <= addr_d;
      store_q    <= store_d;
      iload_q    <= iload_d;
      dload_q    <= dload_d;
    end
  end

`ifdef RAM_ARB_TIMEOUT_EN
  // BUSY-cycle counter and abort flag for the current transaction
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= 16'd0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = (state_q == ST_DONE) && tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  // Only the granted slot sees wait low, and only during DONE
  always_comb begin
    iwait = '1;
    dwait = '1;
    if (state_q == ST_DONE) begin
      for (int c = 0; c < CPUS; c++) begin
        if (2'(c) == gnt_core_q) begin
          if (gnt_data_q) begin
            dwait[c] = 1'b0;
          end else begin
            iwait[c] = 1'b0;
          end
        end
      end
    end
  end

  assign ramREN   = (state_q == ST_BUSY) && !gnt_wr_q;
  assign ramWEN   = (state_q == ST_BUSY) && gnt_wr_q;
  assign ramaddr  = (state_q == ST_BUSY) ? addr_q : 32'd0;
  assign ramstore = (state_q == ST_BUSY) ? store_q : 32'd0;
  assign iload    = iload_q;
  assign dload    = dload_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter (CPUS=2, TIMEOUT=8)

module tb_ram_arbiter;

  localparam int CPUS = 2;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic [CPUS-1:0]       iREN = '0, dREN = '0, dWEN = '0;
  logic [CPUS-1:0][31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [CPUS-1:0]       iwait, dwait;
  logic [CPUS-1:0][31:0] iload, dload;
  logic                  ramREN, ramWEN, timeout_err;
  logic [31:0]           ramaddr, ramstore;
  logic [31:0]           ramload = 32'd0;
  logic [1:0]            ramstate = 2'd0;

  ram_arbiter #(.CPUS(CPUS), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        is_d;
    int          core;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_iload[CPUS];
  logic [31:0] m_dload[CPUS];

  logic        ob_started, ob_ren, ob_wen, ob_stable;
  logic [31:0] ob_addr, ob_store;
  int          ob_gap;

  task automatic do_reset();
    RST = 1'b1;
    iREN = '0; dREN = '0; dWEN = '0; ramstate = 2'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < CPUS; c++) begin
      m_iload[c] = 32'd0;
      m_dload[c] = 32'd0;
    end
  endtask

  // Expected result of one granted transaction, kept in grant order
  task automatic push(input logic is_d, input int core, input logic wr,
                      input logic [31:0] addr, input logic [31:0] store, input logic [31:0] rdata);
    exp_t e;
    e.is_d = is_d; e.core = core; e.wr = wr; e.addr = addr; e.store = wr ? store : 32'd0;
    if (!is_d) begin
      m_iload[core] = rdata;
    end else if (!wr) begin
      m_dload[core] = rdata;
    end
    e.load = is_d ? m_dload[core] : m_iload[core];
    exp_q.push_back(e);
  endtask

  // RAM side model: wait for the bus, answer ERROR/BUSY then ACCESS; returns at the DONE negedge
  task automatic run_txn(input int acc, input int nerr, input logic [31:0] rdata, input bit drop);
    ob_started = 1'b0; ob_gap = 0; ob_stable = 1'b1;
    for (int g = 0; g < 20 && !ob_started; g++) begin
      @(negedge CLK);
      if (ramREN || ramWEN) ob_started = 1'b1;
      else ob_gap++;
    end
    if (!ob_started) return;
    ob_ren = ramREN; ob_wen = ramWEN; ob_addr = ramaddr; ob_store = ramstore;
    for (int b = 1; b <= acc; b++) begin
      if (b > 1) begin
        @(negedge CLK);
        if (ramaddr !== ob_addr || ramstore !== ob_store || ramREN !== ob_ren || ramWEN !== ob_wen)
          ob_stable = 1'b0;
      end
      ramstate = (b == acc) ? 2'd2 : ((b <= nerr) ? 2'd3 : 2'd1);
      ramload  = (b == acc) ? rdata : 32'h0BAD0BAD;
    end
    @(negedge CLK);
    ramstate = 2'd0;
    ramload  = 32'h0;
    if (drop) begin
      for (int c = 0; c < CPUS; c++) begin
        if (!iwait[c]) iREN[c] = 1'b0;
        if (!dwait[c]) begin dREN[c] = 1'b0; dWEN[c] = 1'b0; end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (iwait !== 2'b11 || dwait !== 2'b11) begin
      $display("FAIL reset_waits: iwait=%b dwait=%b, want 11 11", iwait, dwait);
    end else passed++;
    total++;
    if (iload !== '0 || dload !== '0) begin
      $display("FAIL reset_loads: iload=%h dload=%h, want 0", iload, dload);
    end else passed++;
    total++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'd0 || ramstore !== 32'd0 || timeout_err !== 1'b0) begin
      $display("FAIL reset_ram: ren=%b wen=%b addr=%h store=%h terr=%b, want all 0",
               ramREN, ramWEN, ramaddr, ramstore, timeout_err);
    end else passed++;
  endtask

  task automatic test_single_read();
    exp_t e;
    do_reset();
    iaddr[0] = 32'h100; iREN[0] = 1'b1;
    push(1'b0, 0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
    run_txn(2, 0, exp_q[0].load, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (!ob_started || ob_gap != 0 || ob_ren !== 1'b1 || ob_wen !== 1'b0 || ob_addr !== e.addr) begin
      $display("FAIL single_grant: started=%b gap=%0d ren=%b wen=%b addr=%h, want 1 0 1 0 %h",
               ob_started, ob_gap, ob_ren, ob_wen, ob_addr, e.addr);
    end else passed++;
    total++;
    if (iwait !== 2'b10 || dwait !== 2'b11 || iload[0] !== e.load) begin
      $display("FAIL single_done: iwait=%b dwait=%b iload0=%h, want 10 11 %h", iwait, dwait, iload[0], e.load);
    end else passed++;
    @(negedge CLK);
    total++;
    if (iwait !== 2'b11 || iload[0] !== e.load) begin
      $display("FAIL single_pulse: iwait=%b iload0=%h, want 11 %h", iwait, iload[0], e.load);
    end else passed++;
  endtask

  task automatic test_priority();
    exp_t e;
    logic [1:0] ew_i, ew_d;
    logic [31:0] got;
    do_reset();
    iaddr[0] = 32'h200; daddr[1] = 32'h300; daddr[0] = 32'h400; dstore[0] = 32'h12345678;
    iREN[0] = 1'b1; dREN[1] = 1'b1; dWEN[0] = 1'b1; dREN[0] = 1'b1;
    push(1'b1, 0, 1'b1, 32'h400, 32'h12345678, 32'h0);
    push(1'b1, 1, 1'b0, 32'h300, 32'h0, 32'h11112222);
    push(1'b0, 0, 1'b0, 32'h200, 32'h0, 32'h33334444);
    for (int t = 0; t < 3; t++) begin
      run_txn(2, 0, exp_q[0].load, 1'b1);
      e = exp_q.pop_front();
      ew_i = 2'b11; ew_d = 2'b11;
      if (e.is_d) ew_d[e.core] = 1'b0; else ew_i[e.core] = 1'b0;
      got = e.is_d ? dload[e.core] : iload[e.core];
      total++;
      if (!ob_started || ob_wen !== e.wr || ob_ren !== !e.wr || ob_addr !== e.addr || ob_store !== e.store) begin
        $display("FAIL prio_grant%0d: wen=%b addr=%h store=%h, want wen=%b addr=%h store=%h",
                 t, ob_wen, ob_addr, ob_store, e.wr, e.addr, e.store);
      end else passed++;
      total++;
      if (iwait !== ew_i || dwait !== ew_d || got !== e.load) begin
        $display("FAIL prio_done%0d: iwait=%b dwait=%b load=%h, want %b %b %h",
                 t, iwait, dwait, got, ew_i, ew_d, e.load);
      end else passed++;
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [1:0] ew_d;
    do_reset();
    daddr[0] = 32'h500; daddr[1] = 32'h600; dREN = 2'b11;
    for (int t = 0; t < 4; t++) begin
      push(1'b1, t % 2, 1'b0, (t % 2 == 0) ? 32'h500 : 32'h600, 32'h0, 32'hA0000000 + 32'(t));
    end
    for (int t = 0; t < 4; t++) begin
      run_txn(1 + (t % 2), 0, exp_q[0].load, 1'b0);
      e = exp_q.pop_front();
      ew_d = 2'b11; ew_d[e.core] = 1'b0;
      total++;
      if (!ob_started || ob_addr !== e.addr || ob_gap != ((t == 0) ? 0 : 1)) begin
        $display("FAIL rr_grant%0d: started=%b addr=%h gap=%0d, want addr=%h gap=%0d",
                 t, ob_started, ob_addr, ob_gap, e.addr, (t == 0) ? 0 : 1);
      end else passed++;
      total++;
      if (dwait !== ew_d || iwait !== 2'b11 || dload[e.core] !== e.load) begin
        $display("FAIL rr_done%0d: dwait=%b iwait=%b load=%h, want %b 11 %h",
                 t, dwait, iwait, dload[e.core], ew_d, e.load);
      end else passed++;
    end
    dREN = 2'b00;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_error_retry();
    exp_t e;
    int extra;
    do_reset();
    daddr[1] = 32'h700; dREN[1] = 1'b1;
    push(1'b1, 1, 1'b0, 32'h700, 32'h0, 32'hCAFEF00D);
    run_txn(4, 3, exp_q[0].load, 1'b1);
    e = exp_q.pop_front();
    total++;
    if (!ob_started || !ob_stable || ob_addr !== e.addr) begin
      $display("FAIL err_stable: started=%b stable=%b addr=%h, want 1 1 %h", ob_started, ob_stable, ob_addr, e.addr);
    end else passed++;
    total++;
    if (dwait !== 2'b01 || dload[1] !== e.load) begin
      $display("FAIL err_done: dwait=%b dload1=%h, want 01 %h", dwait, dload[1], e.load);
    end else passed++;
    extra = 0;
    repeat (4) begin
      @(negedge CLK);
      if (dwait !== 2'b11 || ramREN !== 1'b0) extra++;
    end
    total++;
    if (extra != 0) begin
      $display("FAIL err_single_pulse: %0d cycles with activity after DONE, want 0", extra);
    end else passed++;
  endtask

  task automatic test_timeout();
    int n;
    logic seen;
    do_reset();
    daddr[0] = 32'h800; dREN[0] = 1'b1;
    seen = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(negedge CLK);
      seen = ramREN;
    end
    ramstate = 2'd1;
`ifdef RAM_ARB_TIMEOUT_EN
    n = 0;
    while (seen && dwait[0] !== 1'b0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    total++;
    if (!seen || n != 8 || timeout_err !== 1'b1 || dload[0] !== 32'hBAD1BAD1) begin
      $display("FAIL timeout_abort: started=%b cycles=%0d terr=%b dload0=%h, want 1 8 1 bad1bad1",
               seen, n, timeout_err, dload[0]);
    end else passed++;
    dREN[0] = 1'b0;
    @(negedge CLK);
    total++;
    if (timeout_err !== 1'b0 || dwait !== 2'b11) begin
      $display("FAIL timeout_pulse: terr=%b dwait=%b, want 0 11", timeout_err, dwait);
    end else passed++;
    ramstate = 2'd0;
`else
    n = 0;
    repeat (20) begin
      @(negedge CLK);
      if (dwait[0] !== 1'b1 || ramREN !== 1'b1 || timeout_err !== 1'b0) n++;
    end
    total++;
    if (!seen || n != 0) begin
      $display("FAIL no_timeout_hold: started=%b bad_cycles=%0d, want 1 0", seen, n);
    end else passed++;
    ramstate = 2'd2; ramload = 32'h5A5A5A5A;
    @(negedge CLK);
    ramstate = 2'd0;
    total++;
    if (dwait[0] !== 1'b0 || dload[0] !== 32'h5A5A5A5A) begin
      $display("FAIL no_timeout_finish: dwait0=%b dload0=%h, want 0 5a5a5a5a", dwait[0], dload[0]);
    end else passed++;
    dREN[0] = 1'b0;
    @(negedge CLK);
`endif
  endtask

  task automatic test_reset_mid();
    logic seen;
    int bad;
    iaddr[1] = 32'h900; iREN[1] = 1'b1;
    seen = 1'b0;
    for (int g = 0; g < 20 && !seen; g++) begin
      @(negedge CLK);
      seen = ramREN;
    end
    ramstate = 2'd1;
    RST = 1'b1;
    iREN[1] = 1'b0;
    @(negedge CLK);
    total++;
    if (!seen || iwait !== 2'b11 || dwait !== 2'b11 || iload !== '0 || dload !== '0 ||
        ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'd0) begin
      $display("FAIL reset_mid: started=%b iwait=%b dwait=%b iload=%h dload=%h ren=%b addr=%h, want 1 11 11 0 0 0 0",
               seen, iwait, dwait, iload, dload, ramREN, ramaddr);
    end else passed++;
    RST = 1'b0;
    ramstate = 2'd2;
    bad = 0;
    repeat (4) begin
      @(negedge CLK);
      if (iwait !== 2'b11 || dwait !== 2'b11 || ramREN !== 1'b0) bad++;
    end
    ramstate = 2'd0;
    total++;
    if (bad != 0) begin
      $display("FAIL reset_mid_idle: %0d active cycles after reset, want 0", bad);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_priority();
    test_round_robin();
    test_error_retry();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
